// File: rtl/apb_fabric_pkg.sv
// Shared types, default platform address map and match helper for the APB fabric.
package apb_fabric_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TSETUP,
        TACCESS,
        RESP
    } fabric_state_e;

    localparam int DEF_N_TGT  = 5;
    localparam int DEF_ADDR_W = 34;

    // Index 0 sits in the least-significant slice: RAM, UART, MTIMER, PLIC, ROM.
    localparam logic [DEF_N_TGT*DEF_ADDR_W-1:0] DEF_TGT_BASE = {
        34'h0_f000_0000, 34'h0_9000_0000, 34'h0_8001_0000, 34'h0_8000_0000, 34'h0_0000_0000
    };
    localparam logic [DEF_N_TGT*DEF_ADDR_W-1:0] DEF_TGT_MASK = {
        34'h3_ffff_0000, 34'h3_fc00_0000, 34'h3_ffff_0000, 34'h3_ffff_f000, 34'h3_8000_0000
    };

    // Operands are zero-extended to 64 bits so one helper serves any ADDR_W up to 64.
    function automatic logic match_addr(input logic [63:0] addr,
                                        input logic [63:0] base,
                                        input logic [63:0] mask);
        return (addr & mask) == (base & mask);
    endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational base/mask decoder: one-hot priority select, hit flag and in-region offset.
module apb_addr_decoder
    import apb_fabric_pkg::*;
#(
    parameter int                        N_TGT  = DEF_N_TGT,
    parameter int                        ADDR_W = DEF_ADDR_W,
    parameter logic [N_TGT*ADDR_W-1:0]   BASE   = DEF_TGT_BASE,
    parameter logic [N_TGT*ADDR_W-1:0]   MASK   = DEF_TGT_MASK
) (
    input  logic [ADDR_W-1:0] paddr_i,
    output logic [N_TGT-1:0]  sel_o,
    output logic              hit_o,
    output logic [ADDR_W-1:0] offset_o
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        sel_o    = '0;
        hit_o    = 1'b0;
        offset_o = paddr_i;
        // Walking downwards lets the lowest matching index overwrite the others.
        for (int i = N_TGT - 1; i >= 0; i--) begin
            if (match_addr(64'(paddr_i), 64'(BASE[i*ADDR_W +: ADDR_W]),
                           64'(MASK[i*ADDR_W +: ADDR_W]))) begin
                sel_o    = '0;
                sel_o[i] = 1'b1;
                hit_o    = 1'b1;
                offset_o = paddr_i & ~MASK[i*ADDR_W +: ADDR_W];
            end
        end
    end

endmodule

// File: rtl/apb_fabric_n.sv
// Registered 1-to-N APB fabric: latches the request, replays it to the decoded
// target and bounds the target access phase with a timeout.
module apb_fabric_n
    import apb_fabric_pkg::*;
#(
    parameter int                        N_TGT    = DEF_N_TGT,
    parameter int                        ADDR_W   = DEF_ADDR_W,
    parameter logic [N_TGT*ADDR_W-1:0]   TGT_BASE = DEF_TGT_BASE,
    parameter logic [N_TGT*ADDR_W-1:0]   TGT_MASK = DEF_TGT_MASK,
    parameter int                        TIMEOUT  = 255,
    parameter int                        TO_W     = $clog2(TIMEOUT + 2)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                core_i_psel,
    input  logic                core_i_penable,
    output logic                core_i_pready,
    input  logic [ADDR_W-1:0]   core_i_paddr,
    input  logic                core_i_pwrite,
    input  logic [31:0]         core_i_pwdata,
    input  logic [3:0]          core_i_pwstrb,
    output logic [31:0]         core_i_prdata,
    output logic                core_i_pslverr,
    output logic [N_TGT-1:0]    tgt_t_psel,
    output logic                tgt_t_penable,
    input  logic [N_TGT-1:0]    tgt_t_pready,
    output logic [ADDR_W-1:0]   tgt_t_paddr,
    output logic                tgt_t_pwrite,
    output logic [31:0]         tgt_t_pwdata,
    output logic [3:0]          tgt_t_pwstrb,
    input  logic [N_TGT*32-1:0] tgt_t_prdata,
    input  logic [N_TGT-1:0]    tgt_t_pslverr,
    output logic                decerr_evt,
    output logic                timeout_evt
);

    fabric_state_e     state_q;
    logic [N_TGT-1:0]  sel_q, psel_q;
    logic              penable_q, pwrite_q, pready_q, pslverr_q, decerr_q, timeout_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       pwdata_q, prdata_q;
    logic [3:0]        pwstrb_q;
    logic [TO_W-1:0]   cnt_q;

    logic [N_TGT-1:0]  dec_sel;
    logic              dec_hit;
    logic [ADDR_W-1:0] dec_offset;
    logic              tgt_ready, tgt_err;
    logic [31:0]       tgt_rdata;

    apb_addr_decoder #(
        .N_TGT  (N_TGT),
        .ADDR_W (ADDR_W),
        .BASE   (TGT_BASE),
        .MASK   (TGT_MASK)
    ) u_dec (
        .paddr_i  (core_i_paddr),
        .sel_o    (dec_sel),
        .hit_o    (dec_hit),
        .offset_o (dec_offset)
    );

    // One-hot AND-OR mux of the selected target's response.
    always_comb begin
        tgt_ready = |(tgt_t_pready & sel_q);
        tgt_rdata = '0;
        tgt_err   = 1'b0;
        for (int i = 0; i < N_TGT; i++) begin
            if (sel_q[i]) begin
                tgt_rdata = tgt_rdata | tgt_t_prdata[32*i +: 32];
                tgt_err   = tgt_err | tgt_t_pslverr[i];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            addr_q    <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pwstrb_q  <= '0;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            decerr_q  <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            decerr_q  <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (core_i_psel && !core_i_penable) begin
                        addr_q   <= dec_offset;
                        pwrite_q <= core_i_pwrite;
                        pwdata_q <= core_i_pwdata;
                        pwstrb_q <= core_i_pwstrb;
                        sel_q    <= dec_sel;
                        if (dec_hit) begin
                            psel_q  <= dec_sel;
                            state_q <= TSETUP;
                        end else begin
                            pready_q  <= 1'b1;
                            prdata_q  <= '0;
                            pslverr_q <= 1'b1;
                            decerr_q  <= 1'b1;
                            state_q   <= RESP;
                        end
                    end
                end
                TSETUP: begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= TACCESS;
                end
                TACCESS: begin
                    if (tgt_ready) begin
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        pready_q  <= 1'b1;
                        prdata_q  <= tgt_rdata;
                        pslverr_q <= tgt_err;
                        state_q   <= RESP;
                    end else if (TIMEOUT != 0 && cnt_q == TO_W'(TIMEOUT - 1)) begin
                        psel_q    <= '0;
                        penable_q <= 1'b0;
                        pready_q  <= 1'b1;
                        prdata_q  <= '0;
                        pslverr_q <= 1'b1;
                        timeout_q <= 1'b1;
                        state_q   <= RESP;
                    end else begin
                        cnt_q <= cnt_q + TO_W'(1);
                    end
                end
                RESP: begin
                    pready_q  <= 1'b0;
                    prdata_q  <= '0;
                    pslverr_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign core_i_pready  = pready_q;
    assign core_i_prdata  = prdata_q;
    assign core_i_pslverr = pslverr_q;
    assign tgt_t_psel     = psel_q;
    assign tgt_t_penable  = penable_q;
    assign tgt_t_paddr    = addr_q;
    assign tgt_t_pwrite   = pwrite_q;
    assign tgt_t_pwdata   = pwdata_q;
    assign tgt_t_pwstrb   = pwstrb_q;
    assign decerr_evt     = decerr_q;
    assign timeout_evt    = timeout_q;

endmodule

// File: tb/tb_apb_fabric_n.sv
// Scoreboard bench for apb_fabric_n on the default five-region map with TIMEOUT=8.
module tb_apb_fabric_n;

    localparam int N  = 5;
    localparam int AW = 34;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            core_i_psel, core_i_penable, core_i_pready, core_i_pwrite, core_i_pslverr;
    logic [AW-1:0]   core_i_paddr;
    logic [31:0]     core_i_pwdata, core_i_prdata;
    logic [3:0]      core_i_pwstrb;
    logic [N-1:0]    tgt_t_psel, tgt_t_pready, tgt_t_pslverr;
    logic            tgt_t_penable, tgt_t_pwrite, decerr_evt, timeout_evt;
    logic [AW-1:0]   tgt_t_paddr;
    logic [31:0]     tgt_t_pwdata;
    logic [3:0]      tgt_t_pwstrb;
    logic [N*32-1:0] tgt_t_prdata;

    always #5 clk = ~clk;

    apb_fabric_n #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .core_i_psel(core_i_psel), .core_i_penable(core_i_penable), .core_i_pready(core_i_pready),
        .core_i_paddr(core_i_paddr), .core_i_pwrite(core_i_pwrite), .core_i_pwdata(core_i_pwdata),
        .core_i_pwstrb(core_i_pwstrb), .core_i_prdata(core_i_prdata), .core_i_pslverr(core_i_pslverr),
        .tgt_t_psel(tgt_t_psel), .tgt_t_penable(tgt_t_penable), .tgt_t_pready(tgt_t_pready),
        .tgt_t_paddr(tgt_t_paddr), .tgt_t_pwrite(tgt_t_pwrite), .tgt_t_pwdata(tgt_t_pwdata),
        .tgt_t_pwstrb(tgt_t_pwstrb), .tgt_t_prdata(tgt_t_prdata), .tgt_t_pslverr(tgt_t_pslverr),
        .decerr_evt(decerr_evt), .timeout_evt(timeout_evt)
    );

    // Target models: pready rises once the access phase has lasted wait_cfg[i] cycles.
    int          wait_cfg [N] = '{0, 0, 0, 0, 0};
    logic [31:0] rdata_cfg[N] = '{32'h1111_0000, 32'h1234_5678, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    logic        err_cfg  [N] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int          acc_cnt = 0;

    for (genvar g = 0; g < N; g++) begin : g_tgt
        assign tgt_t_pready[g]         = (acc_cnt >= wait_cfg[g]);
        assign tgt_t_prdata[32*g +: 32] = rdata_cfg[g];
        assign tgt_t_pslverr[g]        = err_cfg[g];
    end

    always @(posedge clk) begin
        if (tgt_t_penable && !(|(tgt_t_pready & tgt_t_psel))) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t sb_q[$];

    int total = 0;
    int bad   = 0;

    int            lat, n_dec, n_to, last_psel_lat;
    logic [N-1:0]  psel_t1;
    logic          pen_t1, pen_t2, stable_ok;
    logic [AW-1:0] paddr_t1;

    // Runs one requester transfer starting #1 after an edge; tgt<0 means unmapped.
    task automatic do_xfer(input logic [AW-1:0] addr, input logic wr, input logic [31:0] wd,
                           input logic [3:0] st, input int tgt, input logic exp_to);
        exp_t e, got;
        bit   done;
        if (tgt < 0 || exp_to) begin
            e.rdata = 32'h0; e.err = 1'b1;
        end else begin
            e.rdata = rdata_cfg[tgt]; e.err = err_cfg[tgt];
        end
        sb_q.push_back(e);
        core_i_psel = 1'b1; core_i_penable = 1'b0; core_i_paddr = addr;
        core_i_pwrite = wr; core_i_pwdata = wd; core_i_pwstrb = st;
        n_dec = 0; n_to = 0; last_psel_lat = 0; stable_ok = 1'b1;
        psel_t1 = '0; pen_t1 = 1'b0; pen_t2 = 1'b0; paddr_t1 = '0;
        @(posedge clk); #1;
        core_i_penable = 1'b1;
        lat = 1;
        done = 1'b0;
        while (!done && lat <= 60) begin
            if (lat == 1) begin
                psel_t1 = tgt_t_psel; pen_t1 = tgt_t_penable; paddr_t1 = tgt_t_paddr;
            end
            if (lat == 2) pen_t2 = tgt_t_penable;
            if (decerr_evt) n_dec++;
            if (timeout_evt) n_to++;
            if (tgt_t_psel != '0) begin
                last_psel_lat = lat;
                if (tgt_t_pwdata !== wd || tgt_t_pwstrb !== st || tgt_t_pwrite !== wr ||
                    tgt_t_paddr !== paddr_t1) stable_ok = 1'b0;
            end
            if (core_i_pready) done = 1'b1;
            else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        got = sb_q.pop_front();
        total++;
        if (!done) begin
            bad++;
            $display("FAIL xfer_wait addr=%h: no core_i_pready within 60 cycles", addr);
        end else begin
            total++;
            if (core_i_prdata !== got.rdata) begin
                bad++;
                $display("FAIL sb_rdata addr=%h: got %h want %h", addr, core_i_prdata, got.rdata);
            end
            if (core_i_pslverr !== got.err) begin
                bad++;
                $display("FAIL sb_pslverr addr=%h: got %b want %b", addr, core_i_pslverr, got.err);
            end
        end
        @(posedge clk); #1;
        core_i_psel = 1'b0; core_i_penable = 1'b0;
        total++;
        if (core_i_pready !== 1'b0 || core_i_prdata !== 32'h0 || core_i_pslverr !== 1'b0) begin
            bad++;
            $display("FAIL resp_one_cycle addr=%h: pready=%b prdata=%h pslverr=%b want 0",
                     addr, core_i_pready, core_i_prdata, core_i_pslverr);
        end
    endtask

    task automatic check_all_zero(input string name);
        total++;
        if ({tgt_t_psel, tgt_t_penable, core_i_pready, core_i_prdata, core_i_pslverr, decerr_evt,
             timeout_evt, tgt_t_paddr, tgt_t_pwrite, tgt_t_pwdata, tgt_t_pwstrb} !== '0) begin
            bad++;
            $display("FAIL %s: psel=%b pen=%b pready=%b prdata=%h err=%b dec=%b to=%b paddr=%h want all 0",
                     name, tgt_t_psel, tgt_t_penable, core_i_pready, core_i_prdata, core_i_pslverr,
                     decerr_evt, timeout_evt, tgt_t_paddr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        core_i_psel = 1'b0; core_i_penable = 1'b0; core_i_paddr = '0;
        core_i_pwrite = 1'b0; core_i_pwdata = '0; core_i_pwstrb = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset_outputs");
        rst = 1'b0;
        @(posedge clk); #1;
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_uart_read();
        do_xfer(34'h0_8000_0004, 1'b0, 32'h0, 4'h0, 1, 1'b0);
        total++;
        if (lat !== 3) begin bad++; $display("FAIL uart_latency: got %0d want 3", lat); end
        total++;
        if (psel_t1 !== 5'b00010 || pen_t1 !== 1'b0) begin
            bad++; $display("FAIL uart_setup: psel=%b pen=%b want 00010/0", psel_t1, pen_t1);
        end
        total++;
        if (pen_t2 !== 1'b1) begin bad++; $display("FAIL uart_access: pen=%b want 1", pen_t2); end
        total++;
        if (paddr_t1 !== 34'h4) begin bad++; $display("FAIL uart_offset: got %h want 004", paddr_t1); end
        total++;
        if (n_dec !== 0 || n_to !== 0) begin
            bad++; $display("FAIL uart_events: dec=%0d to=%0d want 0/0", n_dec, n_to);
        end
    endtask

    task automatic test_wait_write();
        wait_cfg[3] = 4;
        do_xfer(34'h0_9000_0010, 1'b1, 32'hdead_beef, 4'hf, 3, 1'b0);
        wait_cfg[3] = 0;
        total++;
        if (lat !== 7) begin bad++; $display("FAIL plic_wait_latency: got %0d want 7", lat); end
        total++;
        if (stable_ok !== 1'b1) begin bad++; $display("FAIL plic_hold: shared outputs changed, want stable"); end
        total++;
        if (psel_t1 !== 5'b01000 || paddr_t1 !== 34'h10) begin
            bad++; $display("FAIL plic_route: psel=%b paddr=%h want 01000/010", psel_t1, paddr_t1);
        end
    endtask

    task automatic test_decerr();
        do_xfer(34'h0_a000_0000, 1'b0, 32'h0, 4'h0, -1, 1'b0);
        total++;
        if (lat !== 1) begin bad++; $display("FAIL decerr_latency: got %0d want 1", lat); end
        total++;
        if (n_dec !== 1) begin bad++; $display("FAIL decerr_pulse: got %0d want 1", n_dec); end
        total++;
        if (last_psel_lat !== 0) begin
            bad++; $display("FAIL decerr_nosel: psel seen at cycle %0d want none", last_psel_lat);
        end
    endtask

    task automatic test_timeout();
        wait_cfg[4] = 1000;
        do_xfer(34'h0_f000_0020, 1'b0, 32'h0, 4'h0, 4, 1'b1);
        total++;
        if (lat !== 10) begin bad++; $display("FAIL timeout_latency: got %0d want 10", lat); end
        total++;
        if (n_to !== 1) begin bad++; $display("FAIL timeout_pulse: got %0d want 1", n_to); end
        total++;
        if (last_psel_lat !== 9) begin
            bad++; $display("FAIL timeout_drop: last psel cycle %0d want 9", last_psel_lat);
        end
        wait_cfg[4] = TO - 1;
        do_xfer(34'h0_f000_0020, 1'b0, 32'h0, 4'h0, 4, 1'b0);
        total++;
        if (lat !== 10 || n_to !== 0) begin
            bad++; $display("FAIL ready_at_limit: lat=%0d to=%0d want 10/0", lat, n_to);
        end
        wait_cfg[4] = 0;
    endtask

    task automatic test_slverr();
        err_cfg[0] = 1'b1;
        do_xfer(34'h0_0000_0100, 1'b1, 32'h5a5a_a5a5, 4'h3, 0, 1'b0);
        err_cfg[0] = 1'b0;
        total++;
        if (paddr_t1 !== 34'h100 || psel_t1 !== 5'b00001) begin
            bad++; $display("FAIL ram_route: psel=%b paddr=%h want 00001/100", psel_t1, paddr_t1);
        end
    endtask

    task automatic test_back_to_back();
        do_xfer(34'h0_8001_0008, 1'b0, 32'h0, 4'h0, 2, 1'b0);
        do_xfer(34'h0_8000_0ffc, 1'b0, 32'h0, 4'h0, 1, 1'b0);
        total++;
        if (lat !== 3 || paddr_t1 !== 34'hffc) begin
            bad++; $display("FAIL b2b_second: lat=%0d paddr=%h want 3/ffc", lat, paddr_t1);
        end
    endtask

    task automatic test_rst_mid();
        wait_cfg[4] = 1000;
        core_i_psel = 1'b1; core_i_penable = 1'b0; core_i_paddr = 34'h0_f000_0000;
        core_i_pwrite = 1'b1; core_i_pwdata = 32'hcafe_f00d; core_i_pwstrb = 4'hf;
        @(posedge clk); #1;
        core_i_penable = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (tgt_t_penable !== 1'b1 || tgt_t_psel !== 5'b10000) begin
            bad++; $display("FAIL rst_mid_access: psel=%b pen=%b want 10000/1", tgt_t_psel, tgt_t_penable);
        end
        rst = 1'b1;
        #1;
        check_all_zero("rst_mid_immediate");
        @(posedge clk); #1;
        check_all_zero("rst_mid_edge");
        rst = 1'b0;
        core_i_psel = 1'b0; core_i_penable = 1'b0;
        wait_cfg[4] = 0;
        @(posedge clk); #1;
        do_xfer(34'h0_0000_0000, 1'b0, 32'h0, 4'h0, 0, 1'b0);
        total++;
        if (lat !== 3) begin bad++; $display("FAIL post_rst_read: lat=%0d want 3", lat); end
    endtask

    initial begin
        test_reset();
        test_uart_read();
        test_wait_write();
        test_decerr();
        test_timeout();
        test_slverr();
        test_back_to_back();
        test_rst_mid();
        total++;
        if (sb_q.size() != 0) begin
            bad++; $display("FAIL sb_drain: %0d entries left want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
